// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_if
// Description : Bundle of every non-clock/reset signal of the decode stage.
//               The fetch side, the writeback port and the execute-facing
//               outputs all live here.
//               master : drives fetch/writeback inputs, observes ID outputs
//               slave  : the decode stage itself
// Ports       : none (parameterised by DATA_W and CNT_W)
// Revision    : 1.0  initial release
// ============================================================================
interface id_stage_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    // fetch side
    logic [31:0]       instr;
    logic              if_valid;
    logic [31:0]       pc4_in;
    logic              flush;
    // writeback port
    logic              wb_en;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    // to execute
    logic [5:0]        op;
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
    logic [31:0]       i_data_2_ex;
    logic [31:0]       pc4_out_2_ex;
    logic              mem_read_2_ex;
    logic              mem_to_reg_2_ex;
    logic              mem_write_2_ex;
    logic [4:0]        rd_add_value_2_ex;
    // status
    logic              stall_out;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output instr, if_valid, pc4_in, flush, wb_en, wb_addr, wb_data,
        input  op, rs, rt, i_data_2_ex, pc4_out_2_ex, mem_read_2_ex,
               mem_to_reg_2_ex, mem_write_2_ex, rd_add_value_2_ex,
               stall_out, halted, instr_count, stall_count
    );

    modport slave (
        input  instr, if_valid, pc4_in, flush, wb_en, wb_addr, wb_data,
        output op, rs, rt, i_data_2_ex, pc4_out_2_ex, mem_read_2_ex,
               mem_to_reg_2_ex, mem_write_2_ex, rd_add_value_2_ex,
               stall_out, halted, instr_count, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Instruction-decode stage. Decodes the fetched instruction,
//               reads the 32x32 register file (with same-cycle writeback
//               bypass), inserts a one-cycle bubble on load-use hazards,
//               honours branch flush and HALT, and keeps saturating
//               issue/stall counters. All outputs except stall_out are
//               registered (one-cycle latency).
// Ports       : clk    - clock, all state on rising edge
//               reset  - synchronous, active-low
//               bus    - id_stage_if.slave: fetch inputs, writeback port,
//                        execute-facing outputs, stall/halt/counters
// Revision    : 1.0  initial release
// ============================================================================
module id_stage #(
    parameter int         DATA_W    = 32,
    parameter int         CNT_W     = 32,
    parameter logic [5:0] BUBBLE_OP = 6'b111111
) (
    input  wire logic   clk,
    input  wire logic   reset,
    id_stage_if.slave   bus
);

    localparam logic [5:0] c_OP_LDW  = 6'b001100;
    localparam logic [5:0] c_OP_STW  = 6'b001101;
    localparam logic [5:0] c_OP_BZ   = 6'b001110;
    localparam logic [5:0] c_OP_BEQ  = 6'b001111;
    localparam logic [5:0] c_OP_JR   = 6'b010000;
    localparam logic [5:0] c_OP_HALT = 6'b010001;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [32];
    logic [5:0]        r_op;
    logic [DATA_W-1:0] r_rs;
    logic [DATA_W-1:0] r_rt;
    logic [31:0]       r_imm;
    logic [31:0]       r_pc4;
    logic              r_mem_read;
    logic              r_mem_to_reg;
    logic              r_mem_write;
    logic [4:0]        r_dest;
    logic              r_halted;
    logic [CNT_W-1:0]  r_icnt;
    logic [CNT_W-1:0]  r_scnt;

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [5:0]  w_opc;
    logic [4:0]  w_rs_a;
    logic [4:0]  w_rt_a;
    logic [4:0]  w_rd_a;
    logic [31:0] w_imm;

    assign w_opc  = bus.instr[31:26];
    assign w_rs_a = bus.instr[25:21];
    assign w_rt_a = bus.instr[20:16];
    assign w_rd_a = bus.instr[15:11];
    assign w_imm  = {{16{bus.instr[15]}}, bus.instr[15:0]};

    // ------------------------------------------------------------------
    // Decode: which registers are read, destination, memory controls
    // ------------------------------------------------------------------
    logic       w_valid;
    logic       w_use_rs;
    logic       w_use_rt;
    logic [4:0] w_dest;
    logic       w_ld;
    logic       w_st;
    logic       w_halt;

    always_comb begin
        w_valid  = 1'b0;
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_dest   = 5'd0;
        w_ld     = 1'b0;
        w_st     = 1'b0;
        w_halt   = 1'b0;
        case (w_opc)
            6'b000000, 6'b000010, 6'b000100,
            6'b000110, 6'b001000, 6'b001010: begin  // R-type ALU
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_dest   = w_rd_a;
            end
            6'b000001, 6'b000011, 6'b000101,
            6'b000111, 6'b001001, 6'b001011: begin  // I-type ALU
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
                w_dest   = w_rt_a;
            end
            c_OP_LDW: begin
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
                w_dest   = w_rt_a;
                w_ld     = 1'b1;
            end
            c_OP_STW: begin
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_st     = 1'b1;
            end
            c_OP_BZ, c_OP_JR: begin
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
            end
            c_OP_BEQ: begin
                w_valid  = 1'b1;
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            c_OP_HALT: begin
                w_valid  = 1'b1;
                w_halt   = 1'b1;
            end
            default: ;  // unknown opcode: issues as a bubble
        endcase
    end

    // ------------------------------------------------------------------
    // Register read with writeback bypass (R0 hard-wired to zero)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;

    always_comb begin
        w_rs_val = '0;
        w_rt_val = '0;
        if (w_rs_a != 5'd0) begin
            if (bus.wb_en && (bus.wb_addr == w_rs_a)) w_rs_val = bus.wb_data;
            else                                       w_rs_val = r_regs[w_rs_a];
        end
        if (w_rt_a != 5'd0) begin
            if (bus.wb_en && (bus.wb_addr == w_rt_a)) w_rt_val = bus.wb_data;
            else                                       w_rt_val = r_regs[w_rt_a];
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard. Only registers the instruction really reads count,
    // so e.g. an I-type whose rt field matches the load target never
    // stalls. The bubble we insert clears r_mem_read next cycle, which
    // bounds every load-use pair to a single stall cycle.
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_issue;

    assign w_stall = reset && bus.if_valid && !bus.flush && !r_halted &&
                     r_mem_read && (r_dest != 5'd0) &&
                     ((w_use_rs && (w_rs_a == r_dest)) ||
                      (w_use_rt && (w_rt_a == r_dest)));

    assign w_issue = bus.if_valid && !bus.flush && !r_halted && !w_stall && w_valid;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
            r_op         <= BUBBLE_OP;
            r_rs         <= '0;
            r_rt         <= '0;
            r_imm        <= '0;
            r_pc4        <= '0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_dest       <= 5'd0;
            r_halted     <= 1'b0;
            r_icnt       <= '0;
            r_scnt       <= '0;
        end else begin
            if (bus.wb_en && (bus.wb_addr != 5'd0))
                r_regs[bus.wb_addr] <= bus.wb_data;

            if (w_stall && (r_scnt != '1))
                r_scnt <= r_scnt + 1'b1;

            if (w_issue) begin
                r_op         <= w_opc;
                r_rs         <= w_rs_val;
                r_rt         <= w_rt_val;
                r_imm        <= w_imm;
                r_pc4        <= bus.pc4_in;
                r_mem_read   <= w_ld;
                r_mem_to_reg <= w_ld;
                r_mem_write  <= w_st;
                r_dest       <= w_dest;
                if (w_halt)
                    r_halted <= 1'b1;
                if (r_icnt != '1)
                    r_icnt <= r_icnt + 1'b1;
            end else begin
                r_op         <= BUBBLE_OP;
                r_rs         <= '0;
                r_rt         <= '0;
                r_imm        <= '0;
                r_pc4        <= '0;
                r_mem_read   <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_mem_write  <= 1'b0;
                r_dest       <= 5'd0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.op                = r_op;
    assign bus.rs                = r_rs;
    assign bus.rt                = r_rt;
    assign bus.i_data_2_ex       = r_imm;
    assign bus.pc4_out_2_ex      = r_pc4;
    assign bus.mem_read_2_ex     = r_mem_read;
    assign bus.mem_to_reg_2_ex   = r_mem_to_reg;
    assign bus.mem_write_2_ex    = r_mem_write;
    assign bus.rd_add_value_2_ex = r_dest;
    assign bus.stall_out         = w_stall;
    assign bus.halted            = r_halted;
    assign bus.instr_count       = r_icnt;
    assign bus.stall_count       = r_scnt;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage. Directed scenarios followed
//               by randomized traffic, all compared against a behavioural
//               model of the decode rules. A second instance with 4-bit
//               counters shares the stimulus to exercise saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_stage;

    localparam logic [5:0] c_BUBBLE = 6'b111111;

    logic clk;
    logic reset;

    id_stage_if #(.DATA_W(32), .CNT_W(32)) bus ();
    id_stage_if #(.DATA_W(32), .CNT_W(4))  bus4 ();

    id_stage #(.DATA_W(32), .CNT_W(32), .BUBBLE_OP(c_BUBBLE)) u_dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    id_stage #(.DATA_W(32), .CNT_W(4), .BUBBLE_OP(c_BUBBLE)) u_dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    assign bus4.instr    = bus.instr;
    assign bus4.if_valid = bus.if_valid;
    assign bus4.pc4_in   = bus.pc4_in;
    assign bus4.flush    = bus.flush;
    assign bus4.wb_en    = bus.wb_en;
    assign bus4.wb_addr  = bus.wb_addr;
    assign bus4.wb_data  = bus.wb_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [31:0] m_regs [32];
    bit          m_halted;
    bit          m_mr;
    logic [4:0]  m_dest;
    longint      m_icnt, m_scnt;
    bit          m_last_stall;
    logic        seen_stall;

    logic [5:0]  e_op;
    logic [31:0] e_rs, e_rt, e_imm, e_pc4;
    bit          e_mr, e_mw, e_issued, e_zero, e_urs, e_urt;
    logic [4:0]  e_dest;

    function automatic longint sat(input longint v, input int w);
        longint mx = (64'sd1 <<< w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Instruction classes straight from the ISA table.
    function automatic void decode(input logic [31:0] ins, output bit ok, output bit urs,
                                   output bit urt, output logic [4:0] dest,
                                   output bit ld, output bit st, output bit hlt);
        logic [5:0] o = ins[31:26];
        ok = 1; urs = 0; urt = 0; dest = 0; ld = 0; st = 0; hlt = 0;
        if (o <= 6'd11 && o[0] == 1'b0) begin urs = 1; urt = 1; dest = ins[15:11]; end
        else if (o <= 6'd11)            begin urs = 1; dest = ins[20:16]; end
        else if (o == 6'd12)            begin urs = 1; dest = ins[20:16]; ld = 1; end
        else if (o == 6'd13)            begin urs = 1; urt = 1; st = 1; end
        else if (o == 6'd14 || o == 6'd16) urs = 1;
        else if (o == 6'd15)            begin urs = 1; urt = 1; end
        else if (o == 6'd17)            hlt = 1;
        else                            ok = 0;
    endfunction

    function automatic logic [31:0] rdval(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
        return m_regs[a];
    endfunction

    task automatic model_pre();
        bit ok, urs, urt, ld, st, hlt, stall, issue;
        logic [4:0] dest, rsa, rta;
        logic [31:0] rsv, rtv;
        decode(bus.instr, ok, urs, urt, dest, ld, st, hlt);
        rsa = bus.instr[25:21];
        rta = bus.instr[20:16];
        stall = reset && bus.if_valid && !bus.flush && !m_halted && m_mr && m_dest != 0 &&
                ((urs && rsa == m_dest) || (urt && rta == m_dest));
        chk("stall_out", {63'd0, bus.stall_out}, {63'd0, stall});
        seen_stall   = bus.stall_out;
        m_last_stall = stall;
        if (!reset) begin
            foreach (m_regs[i]) m_regs[i] = 0;
            m_halted = 0; m_mr = 0; m_dest = 0; m_icnt = 0; m_scnt = 0;
            e_issued = 0; e_zero = 1; e_op = c_BUBBLE; e_mr = 0; e_mw = 0; e_dest = 0;
        end else begin
            rsv = rdval(rsa);
            rtv = rdval(rta);
            if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
            if (stall) m_scnt++;
            issue    = bus.if_valid && !bus.flush && !m_halted && !stall && ok;
            e_issued = issue;
            e_zero   = !issue && (!bus.if_valid || bus.flush || m_halted || stall);
            e_urs    = urs;
            e_urt    = urt;
            if (issue) begin
                e_op = bus.instr[31:26]; e_rs = rsv; e_rt = rtv;
                e_imm = 32'($signed(bus.instr[15:0])); e_pc4 = bus.pc4_in;
                e_mr = ld; e_mw = st; e_dest = dest;
                m_icnt++;
                if (hlt) m_halted = 1;
            end else begin
                e_op = c_BUBBLE; e_mr = 0; e_mw = 0; e_dest = 0;
            end
            m_mr   = e_mr;
            m_dest = e_dest;
        end
    endtask

    task automatic model_post();
        chk("op",         {58'd0, bus.op}, {58'd0, e_op});
        chk("dest",       {59'd0, bus.rd_add_value_2_ex}, {59'd0, e_dest});
        chk("mem_read",   {63'd0, bus.mem_read_2_ex}, {63'd0, e_mr});
        chk("mem_to_reg", {63'd0, bus.mem_to_reg_2_ex}, {63'd0, e_mr});
        chk("mem_write",  {63'd0, bus.mem_write_2_ex}, {63'd0, e_mw});
        chk("halted",     {63'd0, bus.halted}, {63'd0, m_halted});
        chk("instr_count",   {32'd0, bus.instr_count}, 64'(sat(m_icnt, 32)));
        chk("stall_count",   {32'd0, bus.stall_count}, 64'(sat(m_scnt, 32)));
        chk("instr_count4",  {60'd0, bus4.instr_count}, 64'(sat(m_icnt, 4)));
        chk("stall_count4",  {60'd0, bus4.stall_count}, 64'(sat(m_scnt, 4)));
        if (e_issued) begin
            chk("imm", {32'd0, bus.i_data_2_ex}, {32'd0, e_imm});
            chk("pc4", {32'd0, bus.pc4_out_2_ex}, {32'd0, e_pc4});
            if (e_urs) chk("rs", {32'd0, bus.rs}, {32'd0, e_rs});
            if (e_urt) chk("rt", {32'd0, bus.rt}, {32'd0, e_rt});
        end else if (e_zero) begin
            chk("bubble_rs", {32'd0, bus.rs}, 64'd0);
            chk("bubble_rt", {32'd0, bus.rt}, 64'd0);
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_pre();
        @(posedge clk);
        #1;
        model_post();
    endtask

    task automatic cyc(input logic rst_n, input logic v, input logic [31:0] ins,
                       input logic [31:0] pc4, input logic fl, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
        reset        = rst_n;
        bus.if_valid = v;
        bus.instr    = ins;
        bus.pc4_in   = pc4;
        bus.flush    = fl;
        bus.wb_en    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        step();
    endtask

    function automatic logic [31:0] rt_i(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [4:0] d);
        return {o, s, t, d, 11'd0};
    endfunction

    function automatic logic [31:0] it_i(input logic [5:0] o, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] imm);
        return {o, s, t, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        int k = int'($urandom_range(0, 99));
        logic [5:0] o;
        if      (k < 30) o = 6'(2 * $urandom_range(0, 5));
        else if (k < 50) o = 6'(2 * $urandom_range(0, 5) + 1);
        else if (k < 70) o = 6'd12;
        else if (k < 78) o = 6'd13;
        else if (k < 90) o = 6'($urandom_range(14, 16));
        else if (k < 92) o = 6'd17;
        else             o = 6'($urandom_range(18, 63));
        return {o, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 11'($urandom)};
    endfunction

    localparam logic [5:0] c_ADD = 6'd0, c_SUB = 6'd2, c_ADDI = 6'd1, c_ORI = 6'd7;
    localparam logic [5:0] c_LDW = 6'd12, c_BEQ = 6'd15, c_HALT = 6'd17;

    initial begin
        int icnt_before;
        logic [31:0] cur_ins, cur_pc;
        bit cur_v;

        reset = 1'b0;
        bus.instr = 0; bus.if_valid = 0; bus.pc4_in = 0; bus.flush = 0;
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        m_icnt = 0; m_scnt = 0;

        // 1: reset, register writes, first ADD
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_op", {58'd0, bus.op}, {58'd0, c_BUBBLE});
        chk("rst_icnt", {32'd0, bus.instr_count}, 64'd0);
        cyc(1, 0, 0, 0, 0, 1, 5'd1, 32'd5);
        cyc(1, 0, 0, 0, 0, 1, 5'd2, 32'd7);
        cyc(1, 1, rt_i(c_ADD, 1, 2, 3), 32'h104, 0, 0, 0, 0);
        chk("t1_op", {58'd0, bus.op}, 64'd0);
        chk("t1_rs", {32'd0, bus.rs}, 64'd5);
        chk("t1_rt", {32'd0, bus.rt}, 64'd7);
        chk("t1_dest", {59'd0, bus.rd_add_value_2_ex}, 64'd3);
        chk("t1_icnt", {32'd0, bus.instr_count}, 64'd1);

        // 2: bypass plus sign-extended immediate
        cyc(1, 1, it_i(c_ORI, 4, 5, 16'hFFF0), 32'h108, 0, 1, 5'd4, 32'hDEADBEEF);
        chk("t2_rs", {32'd0, bus.rs}, 64'hDEADBEEF);
        chk("t2_imm", {32'd0, bus.i_data_2_ex}, 64'hFFFFFFF0);
        chk("t2_dest", {59'd0, bus.rd_add_value_2_ex}, 64'd5);

        // 3: load-use stall, then the non-dependent variant
        cyc(1, 1, it_i(c_LDW, 1, 6, 16'd8), 32'h10C, 0, 0, 0, 0);
        cyc(1, 1, rt_i(c_ADD, 6, 1, 7), 32'h110, 0, 0, 0, 0);
        chk("t3_stall", {63'd0, seen_stall}, 64'd1);
        chk("t3_bub_op", {58'd0, bus.op}, {58'd0, c_BUBBLE});
        chk("t3_bub_dest", {59'd0, bus.rd_add_value_2_ex}, 64'd0);
        chk("t3_scnt", {32'd0, bus.stall_count}, 64'd1);
        cyc(1, 1, rt_i(c_ADD, 6, 1, 7), 32'h110, 0, 0, 0, 0);
        chk("t3_stall_clear", {63'd0, seen_stall}, 64'd0);
        chk("t3_add_dest", {59'd0, bus.rd_add_value_2_ex}, 64'd7);
        cyc(1, 1, it_i(c_LDW, 1, 6, 16'd8), 32'h114, 0, 0, 0, 0);
        cyc(1, 1, rt_i(c_ADD, 1, 2, 7), 32'h118, 0, 0, 0, 0);
        chk("t3_nostall", {63'd0, seen_stall}, 64'd0);
        chk("t3_scnt_hold", {32'd0, bus.stall_count}, 64'd1);

        // 4: flush discards, and beats a simultaneous hazard
        cyc(1, 1, it_i(c_BEQ, 1, 2, 16'd4), 32'h11C, 0, 0, 0, 0);
        icnt_before = int'(bus.instr_count);
        cyc(1, 1, rt_i(c_SUB, 1, 2, 3), 32'h120, 1, 0, 0, 0);
        chk("t4_flush_op", {58'd0, bus.op}, {58'd0, c_BUBBLE});
        chk("t4_flush_icnt", {32'd0, bus.instr_count}, 64'(icnt_before));
        cyc(1, 1, it_i(c_LDW, 1, 6, 16'd8), 32'h124, 0, 0, 0, 0);
        cyc(1, 1, rt_i(c_ADD, 6, 1, 7), 32'h128, 1, 0, 0, 0);
        chk("t4_flush_nostall", {63'd0, seen_stall}, 64'd0);

        // 5: HALT, later instructions bubble, reset clears
        cyc(1, 1, it_i(c_HALT, 0, 0, 16'd0), 32'h12C, 0, 0, 0, 0);
        chk("t5_halt_op", {58'd0, bus.op}, {58'd0, c_HALT});
        chk("t5_halted", {63'd0, bus.halted}, 64'd1);
        cyc(1, 1, rt_i(c_ADD, 1, 2, 3), 32'h130, 0, 0, 0, 0);
        chk("t5_post_op", {58'd0, bus.op}, {58'd0, c_BUBBLE});
        cyc(1, 1, rt_i(c_ADD, 1, 2, 3), 32'h134, 0, 0, 0, 0);
        cyc(0, 1, rt_i(c_ADD, 1, 2, 3), 32'h138, 0, 0, 0, 0);
        chk("t5_rst_halted", {63'd0, bus.halted}, 64'd0);
        chk("t5_rst_icnt", {32'd0, bus.instr_count}, 64'd0);
        chk("t5_rst_scnt", {32'd0, bus.stall_count}, 64'd0);
        cyc(1, 1, rt_i(c_ADD, 1, 0, 3), 32'h13C, 0, 0, 0, 0);
        chk("t5_r1_zero", {32'd0, bus.rs}, 64'd0);

        // 6: R0 writes ignored and never bypassed; counter saturation
        cyc(1, 1, rt_i(c_ADD, 0, 0, 3), 32'h140, 0, 1, 5'd0, 32'h1234);
        chk("t6_r0_bypass", {32'd0, bus.rs}, 64'd0);
        cyc(1, 1, rt_i(c_ADD, 0, 0, 3), 32'h144, 0, 0, 0, 0);
        chk("t6_r0_read", {32'd0, bus.rt}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, it_i(c_ADDI, 0, 1, 16'(i)), 32'(i * 4), 0, 0, 0, 0);
        chk("t6_sat4", {60'd0, bus4.instr_count}, 64'd15);
        chk("t6_nosat32", {32'd0, bus.instr_count}, 64'd16);

        // randomized traffic; fetch re-presents the instruction on a stall
        cur_ins = 0; cur_pc = 0; cur_v = 0;
        for (int n = 0; n < 3000; n++) begin
            logic rst_n;
            rst_n = !($urandom_range(0, m_halted ? 7 : 299) == 0);
            if (!(m_last_stall && reset)) begin
                cur_ins = rand_instr();
                cur_pc  = $urandom;
                cur_v   = ($urandom_range(0, 9) != 0);
            end
            cyc(rst_n, cur_v, cur_ins, cur_pc, ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
